// File: rtl/hack_cpu_core_regs_pkg.sv
// Hack CPU register/control shared definitions.
// Instruction field positions, run state enum, reset vector default.
package hack_pkg;

  localparam int C_BIT    = 15;
  localparam int A_BIT    = 12;
  localparam int COMP_MSB = 11;
  localparam int COMP_LSB = 6;
  localparam int DEST_A   = 5;
  localparam int DEST_D   = 4;
  localparam int DEST_M   = 3;
  localparam int JMP_LT   = 2;
  localparam int JMP_EQ   = 1;
  localparam int JMP_GT   = 0;

  localparam logic [14:0] RESET_VECTOR_DFLT = 15'h0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

endpackage

// File: rtl/hack_cpu_core_regs_if.sv
// Hack CPU core bus: ROM fetch, ALU operands/results, data memory.
// master = CPU register/control block, slave = ROM/ALU/RAM side.
interface hack_cpu_core_regs_if #(
  parameter int WIDTH     = 16,
  parameter int PC_WIDTH  = 15,
  parameter int CNT_WIDTH = 32
);

  logic [WIDTH-1:0]     instruction;
  logic                 instr_valid;
  logic [WIDTH-1:0]     inM;
  logic [WIDTH-1:0]     alu_out;
  logic                 alu_zr;
  logic                 alu_ng;
  logic [WIDTH-1:0]     alu_x;
  logic [WIDTH-1:0]     alu_y;
  logic [5:0]           alu_ctrl;
  logic [WIDTH-1:0]     outM;
  logic                 writeM;
  logic [PC_WIDTH-1:0]  addressM;
  logic [PC_WIDTH-1:0]  pc;
  logic                 halted;
  logic [CNT_WIDTH-1:0] retired;

  modport master (
    input  instruction, instr_valid, inM,
    input  alu_out, alu_zr, alu_ng,
    output alu_x, alu_y, alu_ctrl,
    output outM, writeM, addressM,
    output pc, halted, retired
  );

  modport slave (
    output instruction, instr_valid, inM,
    output alu_out, alu_zr, alu_ng,
    input  alu_x, alu_y, alu_ctrl,
    input  outM, writeM, addressM,
    input  pc, halted, retired
  );

endinterface

// File: rtl/hack_cpu_core_regs_pc.sv
// Hack program counter: priority reset > load > inc > hold.
// Ports: clk, rst_n (async), reset_i, load_i, inc_i, d_i -> q_o.
module hack_pc #(
  parameter int                  PC_WIDTH     = 15,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reset_i,
  input  logic                load_i,
  input  logic                inc_i,
  input  logic [PC_WIDTH-1:0] d_i,
  output logic [PC_WIDTH-1:0] q_o
);

  logic [PC_WIDTH-1:0] cnt_q;
  logic [PC_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    priority case (1'b1)
      reset_i: cnt_d = RESET_VECTOR;
      load_i:  cnt_d = d_i;
      inc_i:   cnt_d = cnt_q + PC_WIDTH'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RESET_VECTOR;
    else        cnt_q <= cnt_d;
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/hack_cpu_core_regs.sv
// Hack CPU register/control half: A, D, PC, decode, halt, retire count.
// Ports: clk, rst_n (async), soft_reset (sync), bus (master modport).
module hack_cpu_core_regs
  import hack_pkg::*;
#(
  parameter int                  WIDTH        = 16,
  parameter int                  PC_WIDTH     = 15,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DFLT,
  parameter int                  CNT_WIDTH    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                soft_reset,
  hack_cpu_core_regs_if.master bus
);

  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     d_q, d_d;
  logic [CNT_WIDTH-1:0] ret_q, ret_d;
  state_e               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q;

  logic [WIDTH-1:0] ins;
  logic             is_c;
  logic             run;
  logic             exec;
  logic             jump;
  logic             self_loop;
  logic             unused_bits;

  assign ins  = bus.instruction;
  assign is_c = ins[C_BIT];
  assign run  = (state_q == RUN);
  assign exec = bus.instr_valid & run & ~soft_reset;

  assign jump = is_c & (
      (ins[JMP_LT] & bus.alu_ng)
    | (ins[JMP_EQ] & bus.alu_zr)
    | (ins[JMP_GT] & ~bus.alu_ng & ~bus.alu_zr));

  // A jump back onto the current instruction is the Hack idiom for halt.
  assign self_loop = jump & (a_q[PC_WIDTH-1:0] == pc_q);

  // Bits 14:13 of a C-instruction are don't-care in Hack.
  assign unused_bits = ^ins[C_BIT-1:A_BIT+1];

  always_comb begin
    a_d     = a_q;
    d_d     = d_q;
    ret_d   = ret_q;
    state_d = state_q;
    if (soft_reset) begin
      state_d = RUN;
    end else if (exec) begin
      if (!is_c) begin
        a_d = ins;
      end else begin
        if (ins[DEST_A]) a_d = bus.alu_out;
        if (ins[DEST_D]) d_d = bus.alu_out;
      end
      ret_d = ret_q + CNT_WIDTH'(1);
      if (self_loop) state_d = HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      d_q     <= '0;
      ret_q   <= '0;
      state_q <= RUN;
    end else begin
      a_q     <= a_d;
      d_q     <= d_d;
      ret_q   <= ret_d;
      state_q <= state_d;
    end
  end

  // Jump target is the pre-edge A; on a halting self-loop it equals pc.
  hack_pc #(
    .PC_WIDTH     (PC_WIDTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .reset_i (soft_reset),
    .load_i  (exec & jump),
    .inc_i   (exec),
    .d_i     (a_q[PC_WIDTH-1:0]),
    .q_o     (pc_q)
  );

  assign bus.alu_x    = d_q;
  assign bus.alu_y    = ins[A_BIT] ? bus.inM : a_q;
  assign bus.alu_ctrl = ins[COMP_MSB:COMP_LSB];
  assign bus.outM     = bus.alu_out;
  assign bus.addressM = a_q[PC_WIDTH-1:0];
  assign bus.writeM   = exec & is_c & ins[DEST_M] & rst_n;
  assign bus.pc       = pc_q;
  assign bus.halted   = (state_q == HALT);
  assign bus.retired  = ret_q;

endmodule

// File: tb/tb_hack_cpu_core_regs.sv
// Testbench for hack_cpu_core_regs: directed cases plus random stream.
// Behavioural Hack CPU model predicts every observable output.
module tb_hack_cpu_core_regs;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic soft_reset = 1'b0;

  hack_cpu_core_regs_if bus ();

  hack_cpu_core_regs dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .soft_reset (soft_reset),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] mA, mD;
  logic [14:0] mPC;
  bit          mHalt;
  logic [31:0] mRet;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mA = '0; mD = '0; mPC = '0; mHalt = 0; mRet = '0;
  endtask

  task automatic step(input logic [15:0] ins, input bit v,
                      input logic [15:0] ao, input bit zr,
                      input bit ng, input bit sr,
                      input logic [15:0] im);
    bit jmp;
    logic [15:0] nA;
    bus.instruction = ins;
    bus.instr_valid = v;
    bus.alu_out     = ao;
    bus.alu_zr      = zr;
    bus.alu_ng      = ng;
    bus.inM         = im;
    soft_reset      = sr;
    #2;
    check("pc", bus.pc, mPC);
    check("halted", bus.halted, mHalt);
    check("retired", bus.retired, mRet);
    check("alu_x", bus.alu_x, mD);
    check("alu_y", bus.alu_y, ins[12] ? im : mA);
    check("alu_ctrl", bus.alu_ctrl, ins[11:6]);
    check("outM", bus.outM, ao);
    check("addressM", bus.addressM, mA[14:0]);
    check("writeM", bus.writeM,
          v && ins[15] && ins[3] && !mHalt && !sr);
    if (sr) begin
      mPC = '0;
      mHalt = 0;
    end else if (v && !mHalt) begin
      jmp = ins[15] && ((ins[2] && ng) || (ins[1] && zr)
                        || (ins[0] && !ng && !zr));
      nA = mA;
      if (!ins[15]) nA = ins;
      else if (ins[5]) nA = ao;
      if (ins[15] && ins[4]) mD = ao;
      if (jmp && mA[14:0] == mPC) mHalt = 1;
      mPC = jmp ? mA[14:0] : mPC + 15'd1;
      mA = nA;
      mRet = mRet + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic exe(input logic [15:0] ins, input logic [15:0] ao);
    step(ins, 1, ao, ao == 16'h0, ao[15], 0, 16'($urandom));
  endtask

  initial begin
    logic [15:0] r_ins;
    logic [15:0] r_ao;
    logic [14:0] hpc;
    logic [31:0] hret;
    bus.instruction = '0;
    bus.instr_valid = 0;
    bus.alu_out = '0;
    bus.alu_zr = 0;
    bus.alu_ng = 0;
    bus.inM = '0;
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_pc", bus.pc, 15'h0);
    check("rst_ret", bus.retired, 32'h0);
    check("rst_halt", bus.halted, 1'b0);

    // @5 ; D=A
    exe(16'h0005, 16'h0);
    exe(16'hEC10, 16'h0005);
    check("ad_pc", bus.pc, 15'd2);
    check("ad_ret", bus.retired, 32'd2);
    check("ad_D", bus.alu_x, 16'd5);
    check("ad_A", bus.addressM, 15'd5);

    // @0x10 ; M=D+1
    exe(16'h0010, 16'h0);
    bus.instruction = 16'hE7C8;
    bus.instr_valid = 1;
    bus.alu_out = 16'h0006;
    #2;
    check("mw_wr", bus.writeM, 1'b1);
    check("mw_addr", bus.addressM, 15'h0010);
    check("mw_out", bus.outM, 16'h0006);
    bus.instr_valid = 0;
    #1;
    check("mw_stall_wr", bus.writeM, 1'b0);
    @(posedge clk);
    #1;
    check("mw_stall_pc", bus.pc, 15'd3);
    exe(16'hE7C8, 16'h0006);

    // @0x20 ; D;JGT taken, then not taken
    exe(16'h0020, 16'h0);
    step(16'hE301, 1, 16'h0001, 0, 0, 0, 16'h0);
    check("jgt_take", bus.pc, 15'h0020);
    exe(16'h0020, 16'h0);
    step(16'hE301, 1, 16'h8000, 0, 1, 0, 16'h0);
    check("jgt_skip", bus.pc, 15'h0022);

    // Self-loop halt at 7
    step(16'h0, 0, 16'h0, 0, 0, 1, 16'h0);
    for (int i = 0; i < 7; i++) exe(16'h0007, 16'h0);
    check("hl_pre_pc", bus.pc, 15'h0007);
    step(16'hEA87, 1, 16'h0, 1, 0, 0, 16'h0);
    check("hl_flag", bus.halted, 1'b1);
    check("hl_pc", bus.pc, 15'h0007);
    hret = bus.retired;
    check("hl_ret", hret, mRet);
    for (int i = 0; i < 5; i++) exe(16'hEC18, 16'h1234);
    check("hl_hold_pc", bus.pc, 15'h0007);
    check("hl_hold_ret", bus.retired, hret);
    step(16'h0, 1, 16'h0, 0, 0, 1, 16'h0);
    check("sr_pc", bus.pc, 15'h0);
    check("sr_halt", bus.halted, 1'b0);

    // PC wrap 0x7FFF -> 0
    exe(16'h7FFF, 16'h0);
    step(16'hEA87, 1, 16'h0, 1, 0, 0, 16'h0);
    check("wr_pre", bus.pc, 15'h7FFF);
    exe(16'h0001, 16'h0);
    check("wr_pc", bus.pc, 15'h0000);

    // Async reset mid-run, observed without a clock edge
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.instruction = 16'hE7C8;
    bus.instr_valid = 1;
    #1;
    check("ar_D", bus.alu_x, 16'h0);
    check("ar_A", bus.alu_y, 16'h0);
    check("ar_addr", bus.addressM, 15'h0);
    check("ar_pc", bus.pc, 15'h0);
    check("ar_ret", bus.retired, 32'h0);
    check("ar_wr", bus.writeM, 1'b0);
    model_reset();
    #10 rst_n = 1'b1;

    // Random stream
    for (int n = 0; n < 3000; n++) begin
      hpc = mPC + 15'd1;
      case ($urandom_range(0, 9))
        0, 1, 2: r_ins = {1'b0, 15'($urandom)};
        3:       r_ins = {1'b0, hpc};
        4:       r_ins = 16'hEA87;
        default: r_ins = {3'b111, 13'($urandom)};
      endcase
      r_ao = 16'($urandom);
      if ($urandom_range(0, 7) == 0) r_ao = 16'h0;
      step(r_ins, $urandom_range(0, 99) < 85, r_ao,
           r_ao == 16'h0, r_ao[15],
           $urandom_range(0, 99) < 3, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hack_cpu_core_regs.md
Name: hack_cpu_core_regs

Overview:
- Register/control half of the Hack CPU. Holds the A and D registers and the PC, and decodes the 16-bit instruction.
- Drives the ALU operands and control bits. Consumes the ALU result and flags. The ALU is built from the 16-bit inverter/and/adder chips.
- Generates data-memory write strobes and branch targets.
- Adds an instruction-valid hold, HALT detection and a retired-instruction counter for MiSTer ROM latency and debug.

Parameters:
- WIDTH, 16, data and instruction width.
- PC_WIDTH, 15, PC and address width.
- RESET_VECTOR, 15'h0000, PC value after any reset.
- CNT_WIDTH, 32, retired-instruction counter width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- soft_reset  in  1  synchronous Hack "reset" pin; high = restart at RESET_VECTOR.
- instruction  in  16  instruction word from ROM.
- instr_valid  in  1  instruction is valid this cycle; low = stall, no state change.
- inM  in  16  data-memory read value at addressM.
- alu_out  in  16  ALU result.
- alu_zr  in  1  ALU zero flag.
- alu_ng  in  1  ALU negative flag.
- alu_x  out  16  ALU x operand (D).
- alu_y  out  16  ALU y operand (A or inM).
- alu_ctrl  out  6  zx,nx,zy,ny,f,no taken from instruction[11:6].
- outM  out  16  data to memory (= alu_out).
- writeM  out  1  memory write strobe.
- addressM  out  15  A[14:0].
- pc  out  15  address of the next instruction fetch.
- halted  out  1  sticky halt flag.
- retired  out  32  count of executed instructions.

Behaviour:
- Reset (rst_n low, asynchronous): A=0, D=0, pc=RESET_VECTOR, halted=0, retired=0, state=RUN. writeM reads 0 while reset is asserted.
- soft_reset at a clock edge: pc=RESET_VECTOR, halted=0, state=RUN. A, D and retired are unchanged. soft_reset overrides instr_valid and any jump in the same cycle.
- Decode:
  - A-instruction: instruction[15]=0.
  - C-instruction: a=[12], comp=[11:6], dest d1(A)=[5], d2(D)=[4], d3(M)=[3], jump j1(<0)=[2], j2(=0)=[1], j3(>0)=[0].
- Combinational outputs:
  - alu_x = D.
  - alu_y = a ? inM : A.
  - alu_ctrl = comp.
  - outM = alu_out.
  - addressM = A[14:0], using the pre-edge value of A.
  - writeM = instr_valid & C & d3 & (state==RUN) & rst_n & ~soft_reset.
- Execute edge (instr_valid=1, state=RUN, no soft_reset):
  - A-instruction: A <= instruction.
  - C-instruction: if d1, A <= alu_out. If d2, D <= alu_out. The ALU sees pre-edge A and D, so writing both A and D is legal.
  - jump = C & ((j1&alu_ng) | (j2&alu_zr) | (j3&~alu_ng&~alu_zr)).
  - pc <= jump ? A[14:0] (pre-edge) : pc+1.
  - pc+1 wraps 15'h7FFF -> 15'h0000.
  - retired <= retired+1, wrapping at 2^32-1 -> 0.
- Stall (instr_valid=0): no register changes, writeM=0.
- State machine RUN / HALT:
  - RUN -> HALT on an executed C-instruction with jump=1 and A[14:0]==pc, i.e. a self-loop "@X; 0;JMP" at X.
  - On that edge the pc stays equal, halted <= 1 and retired still increments.
  - In HALT: no A/D/pc/retired updates and writeM=0.
  - HALT -> RUN only via soft_reset or rst_n.
- Reset mid-stall or mid-HALT returns to RUN at RESET_VECTOR as above.

Decomposition:
- Package hack_pkg holds:
  - instruction field bit positions (A_BIT=12, COMP_MSB/LSB, DEST_A/D/M, JMP_LT/EQ/GT);
  - the state enum {RUN, HALT};
  - the RESET_VECTOR default.
- One sub-module, hack_pc: 15-bit counter with priority reset > load > inc > hold, plus the async rst_n.

Test Plan:
- Reset: drive rst_n low mid-run -> A=0, D=0, pc=0, retired=0, writeM=0 immediately, with no clock edge needed.
- A-instruction then D=A: drive 0x0005, then C-instruction D=A with alu_out=5 -> A=5, D=5, pc=2, retired=2, writeM=0.
- M write: A=0x0010, C-instruction M=D+1 with alu_out=0x0006 -> writeM=1, addressM=0x0010, outM=0x0006. With instr_valid=0 on the same instruction -> writeM=0 and pc held.
- Conditional jump: A=0x0020, D;JGT with alu_zr=0, alu_ng=0 -> pc=0x0020. Repeat with alu_ng=1 -> pc=old+1.
- Halt: pc=0x0007, A=0x0007, 0;JMP -> halted=1, pc=7. Further valid instructions change nothing. Then soft_reset -> pc=0, halted=0.
- Wrap: pc=0x7FFF, executed A-instruction -> pc=0x0000. retired preset near max by running 2^32 instructions (or forced) wraps to 0.
